// File: rtl/pillar_ctrl_pkg.sv
// Shared control definitions for the Pillar core: sequencer state codes
// and instruction-class constants used by the decode and datapath stages.
package pillar_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_FAULT     = 3'd7
  } stage_e;

  // Instruction classes as produced by decode; code 0 is never a valid class.
  localparam logic [4:0] IT_RTYPE  = 5'd1;
  localparam logic [4:0] IT_ITYPE  = 5'd2;
  localparam logic [4:0] IT_STYPE  = 5'd3;
  localparam logic [4:0] IT_LTYPE  = 5'd4;
  localparam logic [4:0] IT_BTYPE  = 5'd5;
  localparam logic [4:0] IT_UTYPE  = 5'd6;
  localparam logic [4:0] IT_JTYPE  = 5'd7;
  localparam logic [4:0] IT_JRTYPE = 5'd8;

  function automatic logic itype_legal(input logic [4:0] it);
    return it inside {IT_RTYPE, IT_ITYPE, IT_STYPE, IT_LTYPE,
                      IT_BTYPE, IT_UTYPE, IT_JTYPE, IT_JRTYPE};
  endfunction

endpackage

// File: rtl/stage_ctrl_wdog.sv
// Memory-ack watchdog for stage_ctrl; only instantiated when
// STAGE_CTRL_TIMEOUT_EN is defined.
module stage_ctrl_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_en,
  input  logic ack,
  output logic expire
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Counts completed ack-less cycles; leaving the wait states or an ack clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!wait_en || ack) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th consecutive cycle without an ack.
  assign expire = wait_en && !ack && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/stage_ctrl.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer for the Pillar core.
// Define STAGE_CTRL_TIMEOUT_EN to fault on a memory ack that never arrives.
module stage_ctrl
  import pillar_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic        halt_i,
  input  logic [4:0]  itype_i,
  input  logic        mem_ack_i,
  output logic [2:0]  stage_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        wd_q_o,
  output logic        retire_o,
  output logic [31:0] retire_cnt_o,
  output logic        busy_o,
  output logic        fault_o
);

  stage_e      state_q;
  stage_e      state_nxt;
  logic [4:0]  itype_q;
  logic [31:0] retire_cnt_q;
  logic        retire;
  logic        timeout;
  logic        waiting;
  logic        is_store;
  logic        is_load;

  assign waiting  = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
  assign is_store = (itype_q == IT_STYPE);
  assign is_load  = (itype_q == IT_LTYPE);

`ifdef STAGE_CTRL_TIMEOUT_EN
  stage_ctrl_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .wait_en(waiting),
    .ack    (mem_ack_i),
    .expire (timeout)
  );
`else
  logic [31:0] timeout_cycles_unused;
  assign timeout_cycles_unused = 32'(TIMEOUT_CYCLES);
  assign timeout               = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    retire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack_i)    state_nxt = ST_DECODE;
        else if (timeout) state_nxt = ST_FAULT;
      end
      ST_DECODE: begin
        state_nxt = itype_legal(itype_i) ? ST_EXECUTE : ST_FAULT;
      end
      ST_EXECUTE: begin
        if (is_store || is_load)     state_nxt = ST_MEMORY;
        else if (itype_q == IT_BTYPE) retire   = 1'b1;
        else                          state_nxt = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (mem_ack_i) begin
          if (is_load) state_nxt = ST_WRITEBACK;
          else         retire    = 1'b1;
        end else if (timeout) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_WRITEBACK: begin
        retire = 1'b1;
      end
      default: begin
        state_nxt = state_q;
      end
    endcase
    // A retiring instruction picks the follow-on state: halt beats run.
    if (retire) begin
      if (halt_i)     state_nxt = ST_HALT;
      else if (run_i) state_nxt = ST_FETCH;
      else            state_nxt = ST_IDLE;
    end
  end

  // Moore outputs are registered from the next state so they align with stage_o.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      itype_q      <= '0;
      retire_cnt_q <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      wd_q_o       <= 1'b0;
      busy_o       <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == ST_DECODE) itype_q <= itype_i;
      if (retire) retire_cnt_q <= retire_cnt_q + 32'd1;
      mem_req_o <= (state_nxt == ST_FETCH) || (state_nxt == ST_MEMORY);
      mem_we_o  <= (state_nxt == ST_MEMORY) && is_store;
      wd_q_o    <= (state_nxt == ST_WRITEBACK);
      busy_o    <= !(state_nxt inside {ST_IDLE, ST_HALT, ST_FAULT});
      fault_o   <= (state_nxt == ST_FAULT);
    end
  end

  assign stage_o      = state_q;
  assign ir_we_o      = (state_q == ST_FETCH) && mem_ack_i;
  assign retire_o     = retire;
  assign pc_we_o      = retire;
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_stage_ctrl.sv
// Self-checking bench for stage_ctrl: a per-cycle expectation queue built
// from the instruction-class timing rules, driven with randomized side inputs.
module tb_stage_ctrl;
  import pillar_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_i = 1'b0;
  logic        halt_i = 1'b0;
  logic [4:0]  itype_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [2:0]  stage_o;
  logic        mem_req_o, mem_we_o, ir_we_o, pc_we_o, wd_q_o, retire_o;
  logic [31:0] retire_cnt_o;
  logic        busy_o, fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  stage;
    logic        ack;
    logic        we;
    logic        ret;
    logic        run;
    logic        halt;
    logic [4:0]  it;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [31:0] exp_cnt;
  logic [4:0]  legal_t [8] = '{IT_RTYPE, IT_ITYPE, IT_STYPE, IT_LTYPE,
                               IT_BTYPE, IT_UTYPE, IT_JTYPE, IT_JRTYPE};

  stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .halt_i(halt_i),
    .itype_i(itype_i), .mem_ack_i(mem_ack_i), .stage_o(stage_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .ir_we_o(ir_we_o),
    .pc_we_o(pc_we_o), .wd_q_o(wd_q_o), .retire_o(retire_o),
    .retire_cnt_o(retire_cnt_o), .busy_o(busy_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] junk();
    return 5'($urandom);
  endfunction

  // {cnt, stage, req, we, ir_we, pc_we, wd, retire, busy, fault}
  function automatic logic [42:0] exp_vec(input cyc_t e);
    logic req, busy;
    req  = (e.stage == 3'd1) || (e.stage == 3'd4);
    busy = !(e.stage inside {3'd0, 3'd6, 3'd7});
    return {e.cnt, e.stage, req, e.we, e.ack && (e.stage == 3'd1), e.ret,
            (e.stage == 3'd5), e.ret, busy, (e.stage == 3'd7)};
  endfunction

  task automatic push(input logic [2:0] st, input logic ack, input logic we,
                      input logic ret, input logic [4:0] it, input logic run,
                      input logic halt);
    cyc_t e;
    e.stage = st; e.ack = ack; e.we = we; e.ret = ret;
    e.it = it; e.run = run; e.halt = halt; e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (ret) exp_cnt = exp_cnt + 32'd1;
  endtask

  // One instruction: wf fetch waits, wm memory waits; run/halt apply at retire.
  task automatic add_instr(input logic [4:0] it, input int wf, input int wm,
                           input logic run_after, input logic halt_after);
    logic is_b, is_s, is_l;
    is_b = (it == IT_BTYPE);
    is_s = (it == IT_STYPE);
    is_l = (it == IT_LTYPE);
    for (int i = 0; i < wf; i++) push(3'd1, 1'b0, 1'b0, 1'b0, junk(), 1'b1, rbit());
    push(3'd1, 1'b1, 1'b0, 1'b0, junk(), 1'b1, rbit());
    push(3'd2, rbit(), 1'b0, 1'b0, it, 1'b1, rbit());
    if (!(it inside {legal_t})) return;
    if (is_b) push(3'd3, rbit(), 1'b0, 1'b1, junk(), run_after, halt_after);
    else      push(3'd3, rbit(), 1'b0, 1'b0, junk(), 1'b1, rbit());
    if (is_s || is_l) begin
      for (int i = 0; i < wm; i++) push(3'd4, 1'b0, is_s, 1'b0, junk(), 1'b1, rbit());
      if (is_s) push(3'd4, 1'b1, 1'b1, 1'b1, junk(), run_after, halt_after);
      else      push(3'd4, 1'b1, 1'b0, 1'b0, junk(), 1'b1, rbit());
    end
    if (!is_b && !is_s) push(3'd5, rbit(), 1'b0, 1'b1, junk(), run_after, halt_after);
  endtask

  task automatic drive_cycle(input cyc_t e, output logic [42:0] obs);
    @(negedge clk);
    mem_ack_i = e.ack; itype_i = e.it; run_i = e.run; halt_i = e.halt;
    #1;
    obs = {retire_cnt_o, stage_o, mem_req_o, mem_we_o, ir_we_o, pc_we_o,
           wd_q_o, retire_o, busy_o, fault_o};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; run_i = 1'b0; halt_i = 1'b0; mem_ack_i = 1'b0; itype_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    cyc_t e; logic [42:0] obs; int k;
    reset = 1'b0; run_i = 1'b1; mem_ack_i = 1'b1; itype_i = IT_RTYPE;
    @(negedge clk); #1;
    obs = {retire_cnt_o, stage_o, mem_req_o, mem_we_o, ir_we_o, pc_we_o,
           wd_q_o, retire_o, busy_o, fault_o};
    n_checks++;
    if (obs !== 43'd0) begin
      n_fail++; $display("FAIL reset_state obs=%h exp=0", obs);
    end
    do_reset();
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    push(3'd1, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL reset_fetch cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({stage_o, mem_req_o} !== 4'd0) begin
      n_fail++; $display("FAIL reset_midfetch stage/req=%b exp=0000", {stage_o, mem_req_o});
    end
    mem_ack_i = 1'b1; run_i = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({stage_o, retire_cnt_o, ir_we_o, mem_req_o} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_release stage=%0d cnt=%0d ir_we=%b req=%b exp 0", stage_o,
               retire_cnt_o, ir_we_o, mem_req_o);
    end
  endtask

  task automatic test_rtype();
    cyc_t e; logic [42:0] obs; int k;
    do_reset();
    push(3'd0, rbit(), 1'b0, 1'b0, junk(), 1'b1, rbit());
    add_instr(IT_RTYPE, 0, 0, 1'b1, 1'b0);
    push(3'd1, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL rtype cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
  endtask

  task automatic test_load_wait();
    cyc_t e; logic [42:0] obs; int k;
    do_reset();
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    add_instr(IT_LTYPE, 0, 3, 1'b0, 1'b0);
    push(3'd0, rbit(), 1'b0, 1'b0, junk(), 1'b0, rbit());
    push(3'd0, rbit(), 1'b0, 1'b0, junk(), 1'b0, rbit());
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL load_wait cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
  endtask

  task automatic test_store_branch();
    cyc_t e; logic [42:0] obs; int k;
    do_reset();
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    add_instr(IT_STYPE, 1, 2, 1'b1, 1'b0);
    add_instr(IT_BTYPE, 0, 0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL store_branch cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
  endtask

  task automatic test_illegal();
    cyc_t e; logic [42:0] obs; int k;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
      add_instr((pass == 0) ? 5'd0 : 5'($urandom_range(9, 31)), 0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) push(3'd7, rbit(), 1'b0, 1'b0, junk(), i[0], rbit());
      k = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
        if (obs !== exp_vec(e)) begin
          n_fail++; $display("FAIL illegal%0d cyc%0d obs=%h exp=%h", pass, k, obs, exp_vec(e));
        end
        k++;
      end
    end
  endtask

  task automatic test_halt();
    cyc_t e; logic [42:0] obs; int k;
    do_reset();
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    add_instr(IT_ITYPE, 0, 0, 1'b1, 1'b0);
    add_instr(IT_LTYPE, 1, 1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) push(3'd6, rbit(), 1'b0, 1'b0, junk(), rbit(), rbit());
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL halt cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
  endtask

  task automatic test_wrap();
    cyc_t e; logic [42:0] obs; int k;
    do_reset();
    @(negedge clk);
    dut.retire_cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    add_instr(IT_BTYPE, 0, 0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL wrap cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
  endtask

  task automatic test_run_drop();
    cyc_t e; logic [42:0] obs; int k;
    do_reset();
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    add_instr(IT_JRTYPE, 1, 0, 1'b0, 1'b0);
    for (int i = 3; i < exp_q.size(); i++) exp_q[i].run = 1'b0;
    push(3'd0, rbit(), 1'b0, 1'b0, junk(), 1'b0, rbit());
    push(3'd0, rbit(), 1'b0, 1'b0, junk(), 1'b0, rbit());
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL run_drop cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
  endtask

  task automatic test_random();
    cyc_t e; logic [42:0] obs; int k;
    do_reset();
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    for (int n = 0; n < 25; n++)
      add_instr(legal_t[$urandom_range(0, 7)], $urandom_range(0, 2),
                $urandom_range(0, 2), (n != 24), 1'b0);
    push(3'd0, rbit(), 1'b0, 1'b0, junk(), 1'b0, rbit());
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL random cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
  endtask

`ifdef STAGE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    cyc_t e; logic [42:0] obs; int k;
    do_reset();
    push(3'd0, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push(3'd1, 1'b0, 1'b0, 1'b0, junk(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(3'd7, rbit(), 1'b0, 1'b0, junk(), rbit(), 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
      if (obs !== exp_vec(e)) begin
        n_fail++; $display("FAIL timeout cyc%0d obs=%h exp=%h", k, obs, exp_vec(e));
      end
      k++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_branch();
    test_illegal();
    test_halt();
    test_wrap();
    test_run_drop();
    test_random();
`ifdef STAGE_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
